mmio_uart_counter_ctrl: RTL

Memory-mapped I/O controller on the core's data-memory port, in parallel with dmem. It decodes the I/O region (addr[31:28] == 4'h8). It serves UART status/data, a cycle counter and an instruction-retired counter. It returns load data one cycle after the request, aligned with the dmem read latency seen by the writeback mux.

---
 rtl/mmio_uart_counter_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/mmio_uart_counter_ctrl.sv
// ============================================================================
// Module      : mmio_uart_counter_ctrl
// Description : MMIO block at 0x8xxx_xxxx serving UART TX/RX, a cycle counter
//               and an instret counter. Load data is returned one cycle late.
//               Optional RX FIFO enabled by defining MMIO_RX_FIFO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_uart_counter_ctrl #(
  parameter int CPU_CLOCK_FREQ = 50_000_000,
  parameter int RX_FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        re,
  input  logic        we,
  input  logic        instr_retire,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam logic [25:0] c_CTRL = 26'd0;
  localparam logic [25:0] c_RXD  = 26'd1;
  localparam logic [25:0] c_TXD  = 26'd2;
  localparam logic [25:0] c_CYC  = 26'd4;
  localparam logic [25:0] c_INS  = 26'd5;
  localparam logic [25:0] c_CLR  = 26'd6;

  logic        w_sel;
  logic [25:0] w_word;
  logic        w_rd;
  logic        w_wr;
  logic        w_tx_wr;
  logic        w_clr;
  logic        w_rx_rd;
  logic [7:0]  w_rx_byte;
  logic        w_rx_flag;
  logic [2:0]  w_cnt_disp;
  logic [31:0] w_rd_val;
  logic        w_unused;

  logic [31:0] r_rdata;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;
  logic [31:0] r_cycle;
  logic [31:0] r_instret;

  assign w_sel   = (addr[31:28] == 4'h8);
  assign w_word  = addr[27:2];
  // A simultaneous store wins over the load, so such a load returns 0.
  assign w_rd    = re && w_sel && !we;
  assign w_wr    = we && w_sel;
  assign w_tx_wr = w_wr && (w_word == c_TXD);
  assign w_clr   = w_wr && (w_word == c_CLR);
  assign w_rx_rd = w_rd && (w_word == c_RXD);

  assign w_unused = ^{wdata[31:8], addr[1:0], (CPU_CLOCK_FREQ != 0), (RX_FIFO_DEPTH != 0)};

`ifdef MMIO_RX_FIFO_EN
  localparam int              c_AW    = (RX_FIFO_DEPTH > 1) ? $clog2(RX_FIFO_DEPTH) : 1;
  localparam logic [c_AW:0]   c_DEPTH = RX_FIFO_DEPTH[c_AW:0];

  logic [7:0]      r_fifo [RX_FIFO_DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_AW:0]   r_count;
  logic            w_empty;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic [31:0]     w_count32;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == c_DEPTH);
  assign w_push     = rx_valid && !w_full;
  assign w_pop      = w_rx_rd && !w_empty;
  assign w_rx_byte  = r_fifo[r_rd_ptr];
  assign w_rx_flag  = !w_empty;
  assign rx_ready   = !w_full;
  assign w_count32  = {{(31 - c_AW){1'b0}}, r_count};
  assign w_cnt_disp = (w_count32 > 32'd7) ? 3'd7 : w_count32[2:0];

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < RX_FIFO_DEPTH; i++) begin
        r_fifo[i] <= 8'd0;
      end
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= rx_data;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
`else
  logic [7:0] r_rx_byte;
  logic       r_rx_full;

  assign w_rx_byte  = r_rx_byte;
  assign w_rx_flag  = r_rx_full;
  assign rx_ready   = !r_rx_full;
  assign w_cnt_disp = 3'd0;

  // A pop and an arriving byte cannot both act: rx_ready is low while full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_byte <= 8'd0;
      r_rx_full <= 1'b0;
    end else if (w_rx_rd && r_rx_full) begin
      r_rx_full <= 1'b0;
    end else if (rx_valid && !r_rx_full) begin
      r_rx_byte <= rx_data;
      r_rx_full <= 1'b1;
    end
  end
`endif

  always_comb begin
    w_rd_val = 32'd0;
    case (w_word)
      c_CTRL:  w_rd_val = {27'd0, w_cnt_disp, w_rx_flag, !r_tx_valid};
      c_RXD:   w_rd_val = {24'd0, w_rx_byte};
      c_CYC:   w_rd_val = r_cycle;
      c_INS:   w_rd_val = r_instret;
      default: w_rd_val = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= 32'd0;
    end else if (re) begin
      r_rdata <= w_rd ? w_rd_val : 32'd0;
    end
  end

  // A store arriving while the holding register is full is dropped,
  // including the cycle in which the pending byte is handed off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_data  <= 8'd0;
      r_tx_valid <= 1'b0;
    end else if (r_tx_valid) begin
      if (tx_ready) begin
        r_tx_valid <= 1'b0;
      end
    end else if (w_tx_wr) begin
      r_tx_data  <= wdata[7:0];
      r_tx_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle   <= 32'd0;
      r_instret <= 32'd0;
    end else if (w_clr) begin
      r_cycle   <= 32'd0;
      r_instret <= 32'd0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (instr_retire) begin
        r_instret <= r_instret + 32'd1;
      end
    end
  end

  assign rdata    = r_rdata;
  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;

endmodule

`default_nettype wire
